// File: rtl/frame_cfg_arbiter_pkg.sv
// Shared constants and FSM state type for the frame configuration arbiter.
package frame_cfg_pkg;
    localparam int N_REQ_DEF   = 4;
    localparam int N_REGS_DEF  = 8;
    localparam int DATA_W_DEF  = 12;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {IDLE, GRANT, COMMIT} cfg_state_t;
endpackage

// File: rtl/frame_cfg_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);
    always_comb begin : l_pick
        logic [PW-1:0] w_idx;
        gnt   = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(ptr) + k) % N);
            if (!any && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/frame_cfg_arbiter.sv
// Round-robin write arbiter into a shadow config bank, copied to the active bank on vblank rise.
// Optional FRAME_CFG_LOCK_EN adds cfg_lock, which holds the active bank across vblanks.
module frame_cfg_arbiter
    import frame_cfg_pkg::*;
#(
    parameter  int N_REQ  = N_REQ_DEF,
    parameter  int N_REGS = N_REGS_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    localparam int ADDR_W = $clog2(N_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vblnk_in,
`ifdef FRAME_CFG_LOCK_EN
    input  logic                     cfg_lock,
`endif
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REGS*DATA_W-1:0] cfg_out,
    output logic                     commit,
    output logic [FRAME_CNT_W-1:0]   frame_cnt
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    cfg_state_t                r_state;
    logic                      r_vblnk_d;
    logic                      r_pend;
    logic                      r_dirty;
    logic [PW-1:0]             r_ptr;
    logic [N_REQ-1:0]          r_ack;
    logic                      r_commit;
    logic [FRAME_CNT_W-1:0]    r_frame_cnt;
    logic [N_REGS*DATA_W-1:0]  r_shadow;
    logic [N_REGS*DATA_W-1:0]  r_cfg;

    logic [N_REQ-1:0]          w_gnt;
    logic                      w_any;
    logic [PW-1:0]             w_win;
    logic [PW-1:0]             w_nxt_ptr;
    logic [ADDR_W-1:0]         w_addr;
    logic [ADDR_W:0]           w_addr_x;
    logic [DATA_W-1:0]         w_data;
    logic                      w_in_range;
    logic                      w_vb_rise;
    logic                      w_lock;

`ifdef FRAME_CFG_LOCK_EN
    assign w_lock = cfg_lock;
`else
    assign w_lock = 1'b0;
`endif

    assign w_vb_rise = vblnk_in & ~r_vblnk_d;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .any (w_any)
    );

    always_comb begin
        w_win = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) w_win = PW'(k);
        end
    end

    assign w_nxt_ptr  = (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;
    assign w_addr     = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
    assign w_data     = req_data[int'(w_win)*DATA_W +: DATA_W];
    assign w_addr_x   = {1'b0, w_addr};
    // Non-power-of-two banks can be addressed past the end; such writes are acked and dropped.
    assign w_in_range = (w_addr_x < (ADDR_W+1)'(N_REGS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_vblnk_d   <= 1'b0;
            r_pend      <= 1'b0;
            r_dirty     <= 1'b0;
            r_ptr       <= '0;
            r_ack       <= '0;
            r_commit    <= 1'b0;
            r_frame_cnt <= '0;
            r_shadow    <= '0;
            r_cfg       <= '0;
        end else begin
            r_vblnk_d <= vblnk_in;
            r_ack     <= '0;
            r_commit  <= 1'b0;
            // Counting every edge here keeps frame_cnt exact even when the commit is deferred.
            if (w_vb_rise) r_frame_cnt <= r_frame_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_vb_rise || r_pend) begin
                        r_state <= COMMIT;
                        r_pend  <= 1'b0;
                        if (!w_lock) begin
                            r_cfg    <= r_shadow;
                            r_commit <= r_dirty;
                            r_dirty  <= 1'b0;
                        end
                    end else if (w_any) begin
                        r_state <= GRANT;
                        r_ack   <= w_gnt;
                        r_ptr   <= w_nxt_ptr;
                        if (w_in_range) begin
                            r_shadow[int'(w_addr)*DATA_W +: DATA_W] <= w_data;
                            r_dirty <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    if (w_vb_rise) r_pend <= 1'b1;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign commit    = r_commit;
    assign cfg_out   = r_cfg;
    assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_frame_cfg_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model.
module tb_frame_cfg_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        vblnk_in;
    logic [3:0]  req;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [3:0]  ack;
    logic [95:0] cfg_out;
    logic        commit;
    logic [15:0] frame_cnt;
`ifdef FRAME_CFG_LOCK_EN
    logic        cfg_lock;
`endif

    logic [1:0]  req2;
    logic [5:0]  req2_addr;
    logic [23:0] req2_data;
    logic [1:0]  ack2;
    logic [71:0] cfg2;
    logic        commit2;
    logic [15:0] frame2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_cfg_arbiter #(.N_REQ(4), .N_REGS(8), .DATA_W(12)) dut (
        .clk(clk), .rst(rst), .vblnk_in(vblnk_in),
`ifdef FRAME_CFG_LOCK_EN
        .cfg_lock(cfg_lock),
`endif
        .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .cfg_out(cfg_out), .commit(commit), .frame_cnt(frame_cnt)
    );

    frame_cfg_arbiter #(.N_REQ(2), .N_REGS(6), .DATA_W(12)) dut_or (
        .clk(clk), .rst(rst), .vblnk_in(vblnk_in),
`ifdef FRAME_CFG_LOCK_EN
        .cfg_lock(cfg_lock),
`endif
        .req(req2), .req_addr(req2_addr), .req_data(req2_data),
        .ack(ack2), .cfg_out(cfg2), .commit(commit2), .frame_cnt(frame2)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [11:0] cfg_reg(input int k);
        return cfg_out[k*12 +: 12];
    endfunction

    task automatic set_req(input int i, input logic [2:0] a, input logic [11:0] d);
        req[i] = 1'b1;
        req_addr[i*3 +: 3] = a;
        req_data[i*12 +: 12] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; req_addr = '0; req_data = '0; vblnk_in = 1'b0;
        req2 = '0; req2_addr = '0; req2_data = '0;
`ifdef FRAME_CFG_LOCK_EN
        cfg_lock = 1'b0;
`endif
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; req_addr = '0; req_data = '0; vblnk_in = 1'b0;
        req2 = '0; req2_addr = '0; req2_data = '0;
`ifdef FRAME_CFG_LOCK_EN
        cfg_lock = 1'b0;
`endif
        tick();
        checks++;
        if (ack !== 4'b0 || commit !== 1'b0 || cfg_out !== 96'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state ack=%b commit=%b cfg=%h frame=%0d, want all zero", ack, commit, cfg_out, frame_cnt);
        end
        rst = 1'b1; tick();
        set_req(1, 3'd2, 12'hABC);
        tick();
        checks++;
        if (ack !== 4'b0010) begin
            errors++; $display("FAIL reset_pre_ack got %b want 0010", ack);
        end
        rst = 1'b0; req = '0;
        #1;
        checks++;
        if (ack !== 4'b0 || cfg_out !== 96'b0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_midwrite ack=%b cfg=%h frame=%0d, want zeros", ack, cfg_out, frame_cnt);
        end
        tick(); rst = 1'b1; tick();
        vblnk_in = 1'b1; tick();
        checks++;
        if (commit !== 1'b0 || cfg_out !== 96'b0 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL reset_shadow_clear commit=%b cfg=%h frame=%0d, want 0/0/1", commit, cfg_out, frame_cnt);
        end
        vblnk_in = 1'b0; tick();
        set_req(1, 3'd0, 12'h001); set_req(2, 3'd0, 12'h002);
        tick();
        checks++;
        if (ack !== 4'b0010) begin
            errors++; $display("FAIL reset_ptr_zero got %b want 0010", ack);
        end
        req = '0; tick();
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(0, 3'd3, 12'h123);
        tick();
        checks++;
        if (ack !== 4'b0001 || cfg_reg(3) !== 12'h000) begin
            errors++; $display("FAIL single_ack ack=%b cfg3=%h want 0001/000", ack, cfg_reg(3));
        end
        req = '0; tick();
        checks++;
        if (ack !== 4'b0000) begin
            errors++; $display("FAIL single_ack_len got %b want 0000", ack);
        end
        vblnk_in = 1'b1; tick();
        checks++;
        if (cfg_reg(3) !== 12'h123 || commit !== 1'b1 || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_commit cfg3=%h commit=%b frame=%0d want 123/1/1", cfg_reg(3), commit, frame_cnt);
        end
        tick();
        checks++;
        if (commit !== 1'b0 || cfg_reg(3) !== 12'h123) begin
            errors++; $display("FAIL single_commit_len commit=%b cfg3=%h want 0/123", commit, cfg_reg(3));
        end
        vblnk_in = 1'b0; tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_a;
        logic [3:0] seq2 [6];
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 12'(16 * i + 1));
        for (int t = 0; t < 10; t++) begin
            tick();
            exp_a = (t % 2 == 0) ? 4'(1 << ((t / 2) % 4)) : 4'b0;
            checks++;
            if (ack !== exp_a) begin
                errors++; $display("FAIL rr_all t=%0d got %b want %b", t, ack, exp_a);
            end
        end
        req = 4'b1010;
        seq2 = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000};
        for (int t = 0; t < 6; t++) begin
            tick();
            checks++;
            if (ack !== seq2[t]) begin
                errors++; $display("FAIL rr_1010 t=%0d got %b want %b", t, ack, seq2[t]);
            end
        end
        req = '0; tick();
    endtask

    task automatic test_collision();
        do_reset();
        vblnk_in = 1'b1;
        set_req(2, 3'd5, 12'h7FF);
        tick();
        checks++;
        if (ack !== 4'b0 || commit !== 1'b0 || frame_cnt !== 16'd1) begin
            errors++; $display("FAIL coll_commit_first ack=%b commit=%b frame=%0d want 0/0/1", ack, commit, frame_cnt);
        end
        tick();
        checks++;
        if (ack !== 4'b0) begin
            errors++; $display("FAIL coll_idle got %b want 0000", ack);
        end
        tick();
        checks++;
        if (ack !== 4'b0100 || cfg_reg(5) !== 12'h000) begin
            errors++; $display("FAIL coll_ack ack=%b cfg5=%h want 0100/000", ack, cfg_reg(5));
        end
        req = '0; vblnk_in = 1'b0;
        tick(); tick();
        vblnk_in = 1'b1; tick();
        checks++;
        if (cfg_reg(5) !== 12'h7FF || commit !== 1'b1 || frame_cnt !== 16'd2) begin
            errors++;
            $display("FAIL coll_next_frame cfg5=%h commit=%b frame=%0d want 7ff/1/2", cfg_reg(5), commit, frame_cnt);
        end
        vblnk_in = 1'b0; tick();
    endtask

    task automatic test_no_dirty();
        do_reset();
        for (int n = 1; n <= 2; n++) begin
            vblnk_in = 1'b1; tick();
            checks++;
            if (commit !== 1'b0 || frame_cnt !== 16'(n) || cfg_out !== 96'b0) begin
                errors++;
                $display("FAIL nodirty_%0d commit=%b frame=%0d cfg=%h want 0/%0d/0", n, commit, frame_cnt, cfg_out, n);
            end
            vblnk_in = 1'b0; tick(); tick();
        end
        req2 = 2'b01; req2_addr = 6'd6; req2_data = 24'h0003AB;
        tick();
        checks++;
        if (ack2 !== 2'b01) begin
            errors++; $display("FAIL oor_ack got %b want 01", ack2);
        end
        req2 = '0; tick();
        vblnk_in = 1'b1; tick();
        checks++;
        if (commit2 !== 1'b0 || cfg2 !== 72'b0 || frame2 !== 16'd3) begin
            errors++; $display("FAIL oor_no_commit commit=%b cfg=%h frame=%0d want 0/0/3", commit2, cfg2, frame2);
        end
        vblnk_in = 1'b0; tick();
    endtask

`ifdef FRAME_CFG_LOCK_EN
    task automatic test_lock();
        do_reset();
        cfg_lock = 1'b1;
        set_req(0, 3'd0, 12'h555); tick();
        req = '0; tick();
        for (int n = 1; n <= 2; n++) begin
            vblnk_in = 1'b1; tick();
            checks++;
            if (cfg_reg(0) !== 12'h000 || commit !== 1'b0 || frame_cnt !== 16'(n)) begin
                errors++;
                $display("FAIL lock_hold_%0d cfg0=%h commit=%b frame=%0d", n, cfg_reg(0), commit, frame_cnt);
            end
            vblnk_in = 1'b0; tick(); tick();
        end
        cfg_lock = 1'b0;
        vblnk_in = 1'b1; tick();
        checks++;
        if (cfg_reg(0) !== 12'h555 || commit !== 1'b1 || frame_cnt !== 16'd3) begin
            errors++; $display("FAIL lock_release cfg0=%h commit=%b frame=%0d want 555/1/3", cfg_reg(0), commit, frame_cnt);
        end
        vblnk_in = 1'b0; tick();
    endtask
`endif

    // Model: a write is accepted only when the arbiter was idle the cycle before;
    // a pending vblank always wins over requests; winners rotate from the last winner + 1.
    task automatic test_random();
        logic [11:0] sh [8];
        logic [11:0] act [8];
        logic [2:0]  c_addr [4];
        logic [11:0] c_data [4];
        logic [3:0]  c_req, exp_ack;
        logic [95:0] exp_cfg;
        bit          dirty, pend, c_rise, vb, exp_commit, found;
        int          ptr, frames, prev_kind, kind, win, vb_left;
        do_reset();
        for (int i = 0; i < 8; i++) begin sh[i] = '0; act[i] = '0; end
        dirty = 0; pend = 0; ptr = 0; frames = 0; prev_kind = 0; vb = 0; vb_left = 5;
        for (int cyc = 0; cyc < 800; cyc++) begin
            vb_left--;
            if (vb_left == 0) begin vb = !vb; vb_left = $urandom_range(4, 10); end
            c_rise = vb && !vblnk_in;
            vblnk_in = vb;
            for (int i = 0; i < 4; i++)
                if (!req[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)));
            c_req = req;
            for (int i = 0; i < 4; i++) begin
                c_addr[i] = req_addr[i*3 +: 3];
                c_data[i] = req_data[i*12 +: 12];
            end
            tick();
            exp_ack = '0; exp_commit = 0; kind = 0; win = 0;
            if (c_rise) begin pend = 1; frames++; end
            if (prev_kind == 0) begin
                if (pend) begin
                    kind = 2; exp_commit = dirty; dirty = 0; pend = 0;
                    for (int i = 0; i < 8; i++) act[i] = sh[i];
                end else if (c_req != 0) begin
                    found = 0;
                    for (int k = 0; k < 4; k++)
                        if (!found && c_req[(ptr + k) % 4]) begin found = 1; win = (ptr + k) % 4; end
                    kind = 1; exp_ack = 4'(1 << win);
                    sh[c_addr[win]] = c_data[win]; dirty = 1; ptr = (win + 1) % 4;
                end
            end
            prev_kind = kind;
            for (int i = 0; i < 8; i++) exp_cfg[i*12 +: 12] = act[i];
            checks++;
            if (ack !== exp_ack) begin
                errors++; $display("FAIL rand_ack cyc=%0d got %b want %b", cyc, ack, exp_ack);
            end
            checks++;
            if (commit !== exp_commit) begin
                errors++; $display("FAIL rand_commit cyc=%0d got %b want %b", cyc, commit, exp_commit);
            end
            checks++;
            if (cfg_out !== exp_cfg) begin
                errors++; $display("FAIL rand_cfg cyc=%0d got %h want %h", cyc, cfg_out, exp_cfg);
            end
            checks++;
            if (frame_cnt !== 16'(frames)) begin
                errors++; $display("FAIL rand_frame cyc=%0d got %0d want %0d", cyc, frame_cnt, frames);
            end
            for (int i = 0; i < 4; i++) if (exp_ack[i]) req[i] = 1'b0;
        end
        req = '0; vblnk_in = 1'b0; tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_collision();
        test_no_dirty();
`ifdef FRAME_CFG_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
